dcache_direct_wb: RTL and testbench
===================================

# dcache_direct_wb

Direct-mapped, write-back, write-allocate data cache placed between the pipeline's MEM stage and a multi-cycle backing data memory. It accepts one word load/store at a time over a valid/ready handshake, answers hits in one cycle, and on a miss writes back a dirty victim line and fills the new line over a line-wide memory port. The MEM stage stalls on `cpu_req_ready`/`cpu_resp_valid`.

## Interface
- `NUM_SETS`, 16: number of lines. Power of 2, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line. Power of 2, at least 2.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: reset, asynchronous and active-high.
- `cpu_req_valid` in 1: request present.
- `cpu_req_ready` out 1: cache can accept a request. High only in IDLE.
- `cpu_req_write` in 1: 1 = store, 0 = load.
- `cpu_req_addr` in 32: byte address. Bits [1:0] are ignored.
- `cpu_req_wdata` in 32: store data.
- `cpu_resp_valid` out 1: one-cycle pulse when the access completes.
- `cpu_resp_rdata` out 32: load data. For a store, this is the stored word.
- `cpu_resp_hit` out 1: 1 if the first lookup hit; valid with `cpu_resp_valid`.
- `mem_req_valid` out 1: backing-memory request.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_req_write` out 1: 1 = line write-back, 0 = line read.
- `mem_req_addr` out 32: line-aligned byte address.
- `mem_req_wdata` out 32*LINE_WORDS: victim line, with word 0 in the LSBs.
- `mem_resp_valid` in 1: fill data present. Sampled only in AL_WAIT.
- `mem_resp_rdata` in 32*LINE_WORDS: fill line, with word 0 in the LSBs.

## Operation
- Address split: `off` = addr[2+log2(LINE_WORDS)-1:2], `idx` = the next log2(NUM_SETS) bits, `tag` = the remaining upper bits.
- Per-line state: valid bit, dirty bit, tag, data.
  - On reset, valid and dirty are cleared.
  - Tag and data are not reset.
- Request latch: addr, write, and wdata are captured on `cpu_req_valid & cpu_req_ready`. A flag `first_miss` is cleared at the same time.
- IDLE
  - `cpu_req_ready` = 1.
  - On handshake, go to COMPARE.
- COMPARE
  - A hit is `valid[idx] & tag match`.
  - On a hit:
    - Assert `cpu_resp_valid`.
    - `cpu_resp_hit` = !`first_miss`.
    - A load returns `data[idx][off]`.
    - A store writes the word and sets `dirty[idx]`.
    - Go to IDLE.
  - On a miss, set `first_miss`, then:
    - If `valid & dirty`, go to WB_REQ.
    - Otherwise, go to AL_REQ.
- WB_REQ
  - `mem_req_valid` = 1, `mem_req_write` = 1.
  - `mem_req_addr` = {victim tag, idx, 0}.
  - `mem_req_wdata` = victim line.
  - On `mem_req_ready`, the write is complete: clear `dirty[idx]` and go to AL_REQ.
- AL_REQ
  - `mem_req_valid` = 1, `mem_req_write` = 0.
  - `mem_req_addr` = {req tag, idx, 0}.
  - On `mem_req_ready`, go to AL_WAIT.
- AL_WAIT
  - On `mem_resp_valid`: write the line, set valid = 1, dirty = 0, tag = req tag, then go to COMPARE.
  - The re-lookup in COMPARE hits. A store is merged at that point.
- Memory request fields must stay constant while `mem_req_valid & !mem_req_ready`.
- `mem_req_valid` is never asserted in IDLE, COMPARE, or AL_WAIT.
- Unused outputs (`mem_req_wdata` outside WB_REQ, `cpu_resp_rdata` outside the response cycle) are driven to 0.

## Timing
- All outputs are 0 during and after reset, except `cpu_req_ready` = 1 (state IDLE).
- Hit latency: handshake at edge N, then `cpu_resp_valid` is high in the cycle after edge N. This is one cycle.
- Clean-miss latency: 1 (COMPARE) + AL_REQ cycles + AL_WAIT cycles + 1 (COMPARE).
  - With ready and resp both immediate, this is 4 cycles.
- Dirty-miss latency: the clean-miss latency plus the WB_REQ cycles (at least 1).
- `cpu_req_valid` while `cpu_req_ready` = 0 is ignored, with no latching.
- `mem_resp_valid` outside AL_WAIT is ignored.
- Reset asserted mid-operation, in any state:
  - State goes to IDLE immediately.
  - `mem_req_valid` and `cpu_resp_valid` drop without waiting for a clock edge.
  - All lines are invalidated. Dirty data is discarded.
  - The in-flight request is dropped.
- Back-to-back requests: the earliest next handshake is the cycle after `cpu_resp_valid`.

## Test plan
- Cold load miss:
  - Stimulus: after reset, load 0x100. Memory returns line {0x11,0x22,0x33,0x44}.
  - Required: exactly one read, at 0x100. Response rdata = 0x11, hit = 0.
  - Then load 0x104. Required: response one cycle after handshake, rdata = 0x22, hit = 1, no memory traffic.
- Store hit:
  - Stimulus: store 0xDEADBEEF to 0x108 with the line resident.
  - Required: hit = 1, `mem_req_valid` stays 0.
  - Then load 0x108. Required: rdata = 0xDEADBEEF.
- Dirty eviction (defaults, set stride 0x100):
  - Stimulus: load 0x200 after the store hit above.
  - Required: a write to 0x100 whose wdata word 2 = 0xDEADBEEF, then a read at 0x200.
  - Required: response hit = 0, rdata = fill word 0.
- Store miss, write-allocate:
  - Stimulus: store 0x5 to 0x304 into a clean set. Fill returns all zeros.
  - Required: read at 0x300, no write-back, response hit = 0.
  - Then a later load 0x304 returns 0x5 with hit = 1.
- Backpressure:
  - Stimulus: hold `mem_req_ready` = 0 for 5 cycles in AL_REQ.
  - Required: `mem_req_valid` = 1, and addr/write/wdata are unchanged every cycle.
  - Required: `cpu_req_ready` = 0 and `cpu_resp_valid` = 0 throughout.
- Reset mid-miss:
  - Stimulus: assert reset during AL_WAIT.
  - Required: immediately `mem_req_valid` = 0 and `cpu_req_ready` = 1.
  - Then a load of the previously resident 0x100 reports hit = 0.

Source files
------------

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a
// multi-cycle backing memory with a line-wide request/response port.
//
// state     | meaning
// S_IDLE    | ready to accept a CPU request
// S_COMPARE | tag lookup of the latched request, respond on hit
// S_WB_REQ  | write the dirty victim line back to memory
// S_AL_REQ  | request the missing line from memory
// S_AL_WAIT | wait for the fill line
module dcache_direct_wb #(
   parameter int NUM_SETS   = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       cpu_req_valid_i,
   output logic                       cpu_req_ready_o,
   input  logic                       cpu_req_write_i,
   input  logic [31:0]                cpu_req_addr_i,
   input  logic [31:0]                cpu_req_wdata_i,
   output logic                       cpu_resp_valid_o,
   output logic [31:0]                cpu_resp_rdata_o,
   output logic                       cpu_resp_hit_o,
   output logic                       mem_req_valid_o,
   input  logic                       mem_req_ready_i,
   output logic                       mem_req_write_o,
   output logic [31:0]                mem_req_addr_o,
   output logic [32*LINE_WORDS-1:0]   mem_req_wdata_o,
   input  logic                       mem_resp_valid_i,
   input  logic [32*LINE_WORDS-1:0]   mem_resp_rdata_i
);
   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = 30 - OFF_W - IDX_W;
   localparam int LINE_W = 32 * LINE_WORDS;

   typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_WB_REQ, S_AL_REQ, S_AL_WAIT} state_e;

   state_e state_q, state_d;

   logic [NUM_SETS-1:0] valid_q;
   logic [NUM_SETS-1:0] dirty_q;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [LINE_W-1:0]   data_q [NUM_SETS];

   logic [31:2]         addr_q;
   logic                write_q;
   logic [31:0]         wdata_q;
   logic                first_miss_q;

   logic [OFF_W-1:0]    req_off;
   logic [IDX_W-1:0]    req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic [LINE_W-1:0]   cur_line;
   logic                hit;
   logic                req_fire;
   logic                fill_fire;
   logic                unused_addr_lsb;

   assign unused_addr_lsb = ^cpu_req_addr_i[1:0];

   assign req_off   = addr_q[2 +: OFF_W];
   assign req_idx   = addr_q[2+OFF_W +: IDX_W];
   assign req_tag   = addr_q[31 -: TAG_W];
   assign cur_line  = data_q[req_idx];
   assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign req_fire  = cpu_req_valid_i && (state_q == S_IDLE);
   assign fill_fire = (state_q == S_AL_WAIT) && mem_resp_valid_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         addr_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         first_miss_q <= 1'b0;
      end else if (req_fire) begin
         addr_q       <= cpu_req_addr_i[31:2];
         write_q      <= cpu_req_write_i;
         wdata_q      <= cpu_req_wdata_i;
         first_miss_q <= 1'b0;
      end else if ((state_q == S_COMPARE) && !hit) begin
         first_miss_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         case (state_q)
            S_COMPARE: if (hit && write_q) dirty_q[req_idx] <= 1'b1;
            S_WB_REQ:  if (mem_req_ready_i) dirty_q[req_idx] <= 1'b0;
            S_AL_WAIT: if (mem_resp_valid_i) begin
               valid_q[req_idx] <= 1'b1;
               dirty_q[req_idx] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk_i) begin
      if (fill_fire) begin
         data_q[req_idx] <= mem_resp_rdata_i;
         tag_q[req_idx]  <= req_tag;
      end else if ((state_q == S_COMPARE) && hit && write_q) begin
         data_q[req_idx][{req_off, 5'd0} +: 32] <= wdata_q;
      end
   end

   always_comb begin
      state_d          = state_q;
      cpu_req_ready_o  = 1'b0;
      cpu_resp_valid_o = 1'b0;
      cpu_resp_rdata_o = '0;
      cpu_resp_hit_o   = 1'b0;
      mem_req_valid_o  = 1'b0;
      mem_req_write_o  = 1'b0;
      mem_req_addr_o   = '0;
      mem_req_wdata_o  = '0;
      case (state_q)
         S_IDLE: begin
            cpu_req_ready_o = 1'b1;
            if (cpu_req_valid_i) state_d = S_COMPARE;
         end
         S_COMPARE: begin
            if (hit) begin
               cpu_resp_valid_o = 1'b1;
               cpu_resp_hit_o   = !first_miss_q;
               cpu_resp_rdata_o = write_q ? wdata_q : cur_line[{req_off, 5'd0} +: 32];
               state_d          = S_IDLE;
            end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
               state_d = S_WB_REQ;
            end else begin
               state_d = S_AL_REQ;
            end
         end
         S_WB_REQ: begin
            mem_req_valid_o = 1'b1;
            mem_req_write_o = 1'b1;
            mem_req_addr_o  = {tag_q[req_idx], req_idx, {(OFF_W+2){1'b0}}};
            mem_req_wdata_o = cur_line;
            if (mem_req_ready_i) state_d = S_AL_REQ;
         end
         S_AL_REQ: begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
            if (mem_req_ready_i) state_d = S_AL_WAIT;
         end
         S_AL_WAIT: begin
            if (mem_resp_valid_i) state_d = S_COMPARE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_dcache_direct_wb.sv
// Bench for dcache_direct_wb: directed scenarios plus random loads/stores, checked against
// a flat architectural memory and a per-set valid/dirty/tag model.
module tb_dcache_direct_wb;
   localparam int NSETS = 16;
   localparam int LW    = 4;
   localparam int MEMW  = 1024;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          cpu_req_valid_i;
   logic          cpu_req_ready_o;
   logic          cpu_req_write_i;
   logic [31:0]   cpu_req_addr_i;
   logic [31:0]   cpu_req_wdata_i;
   logic          cpu_resp_valid_o;
   logic [31:0]   cpu_resp_rdata_o;
   logic          cpu_resp_hit_o;
   logic          mem_req_valid_o;
   logic          mem_req_ready_i;
   logic          mem_req_write_o;
   logic [31:0]   mem_req_addr_o;
   logic [127:0]  mem_req_wdata_o;
   logic          mem_resp_valid_i;
   logic [127:0]  mem_resp_rdata_i;

   always #5 clk_i = ~clk_i;

   dcache_direct_wb #(.NUM_SETS(NSETS), .LINE_WORDS(LW)) u_dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .cpu_req_valid_i (cpu_req_valid_i),
      .cpu_req_ready_o (cpu_req_ready_o),
      .cpu_req_write_i (cpu_req_write_i),
      .cpu_req_addr_i  (cpu_req_addr_i),
      .cpu_req_wdata_i (cpu_req_wdata_i),
      .cpu_resp_valid_o(cpu_resp_valid_o),
      .cpu_resp_rdata_o(cpu_resp_rdata_o),
      .cpu_resp_hit_o  (cpu_resp_hit_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_write_o (mem_req_write_o),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_wdata_o (mem_req_wdata_o),
      .mem_resp_valid_i(mem_resp_valid_i),
      .mem_resp_rdata_i(mem_resp_rdata_i)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // backing memory (what the DUT sees) and architectural memory (what loads must return)
   logic [31:0]   mem  [MEMW];
   logic [31:0]   gold [MEMW];
   bit            valid_m [NSETS];
   bit            dirty_m [NSETS];
   int unsigned   tag_m   [NSETS];

   typedef struct {
      bit           w;
      logic [31:0]  a;
      logic [127:0] d;
   } mreq_t;
   mreq_t mem_log[$];

   bit fast      = 1'b1;
   bit garbage   = 1'b0;
   bit hold_resp = 1'b0;
   int hold_ready = 0;
   int bp_cnt     = 0;

   bit          acc, pend, prev_stall;
   int          dly;
   logic [31:0] rd_addr;
   mreq_t       acc_r, stall_r;

   // memory responder: acts on negedges, the DUT samples its inputs on posedges
   always @(negedge clk_i) begin
      if (reset_i) begin
         mem_req_ready_i  = 1'b0;
         mem_resp_valid_i = 1'b0;
         mem_resp_rdata_i = '0;
         acc = 0; pend = 0; prev_stall = 0;
      end else begin
         if (mem_resp_valid_i) begin
            mem_resp_valid_i = 1'b0;
            mem_resp_rdata_i = '0;
            pend = 0;
         end
         if (acc) begin
            mem_log.push_back(acc_r);
            if (acc_r.w) begin
               for (int k = 0; k < LW; k++) mem[((acc_r.a >> 2) + k) % MEMW] = acc_r.d[32*k +: 32];
            end else begin
               pend = 1; rd_addr = acc_r.a;
               dly = fast ? 0 : int'($urandom_range(0, 3));
            end
            acc = 0;
         end
         if (prev_stall) begin
            chk("stall_valid", mem_req_valid_o, 1'b1);
            chk("stall_write", mem_req_write_o, stall_r.w);
            chk("stall_addr",  mem_req_addr_o,  stall_r.a);
            chk("stall_wdata", mem_req_wdata_o, stall_r.d);
         end
         prev_stall = 0;
         mem_req_ready_i = 1'b0;
         if (mem_req_valid_o) begin
            if (hold_ready > 0 && !mem_req_write_o) begin
               hold_ready--; bp_cnt++;
            end else begin
               mem_req_ready_i = fast || ($urandom_range(0, 1) == 1);
            end
            acc_r = '{mem_req_write_o, mem_req_addr_o, mem_req_wdata_o};
            if (mem_req_ready_i) acc = 1;
            else begin prev_stall = 1; stall_r = acc_r; end
         end
         if (pend && !hold_resp) begin
            if (dly == 0) begin
               mem_resp_valid_i = 1'b1;
               for (int k = 0; k < LW; k++) mem_resp_rdata_i[32*k +: 32] = mem[((rd_addr >> 2) + k) % MEMW];
            end else dly--;
         end else if (!pend && garbage && $urandom_range(0, 7) == 0) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_rdata_i = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   task automatic model_reset();
      for (int s = 0; s < NSETS; s++) begin valid_m[s] = 0; dirty_m[s] = 0; end
      for (int k = 0; k < MEMW; k++) gold[k] = mem[k];
   endtask

   task automatic start_req(input bit w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk_i);
      chk("req_ready", cpu_req_ready_o, 1'b1);
      cpu_req_valid_i = 1'b1; cpu_req_write_i = w; cpu_req_addr_i = a; cpu_req_wdata_i = d;
      @(posedge clk_i); #1;
      cpu_req_valid_i = 1'b0;
   endtask

   task automatic finish_req(output logic [31:0] rd, output logic hit, output int lat);
      bit got = 0;
      lat = 0; rd = '0; hit = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk_i);
         lat++;
         if (cpu_resp_valid_o) begin
            got = 1; rd = cpu_resp_rdata_o; hit = cpu_resp_hit_o;
            cpu_req_valid_i = 1'b0;
         end else begin
            chk("busy_ready", cpu_req_ready_o, 1'b0);
            // requests while busy must be ignored
            cpu_req_valid_i = ($urandom_range(0, 1) == 1);
            cpu_req_write_i = ($urandom_range(0, 1) == 1);
            cpu_req_addr_i  = $urandom;
            cpu_req_wdata_i = $urandom;
         end
      end
      if (!got) chk("resp_timeout", 1'b0, 1'b1);
   endtask

   task automatic do_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input int exp_lat, input string nm);
      int           idx, wi, lat;
      int unsigned  tg;
      bit           hit_e;
      logic [31:0]  va, rd_e, rd;
      logic [127:0] line;
      logic         hit;
      mreq_t        exp_q[$];
      wi = int'(a[11:2]); idx = int'(a[7:4]); tg = a[31:8];
      hit_e = valid_m[idx] && (tag_m[idx] == tg);
      if (!hit_e) begin
         if (valid_m[idx] && dirty_m[idx]) begin
            va = 32'((tag_m[idx] << 8) | (idx << 4));
            for (int k = 0; k < LW; k++) line[32*k +: 32] = gold[(va >> 2) + k];
            exp_q.push_back('{1'b1, va, line});
         end
         exp_q.push_back('{1'b0, {a[31:4], 4'h0}, 128'h0});
         valid_m[idx] = 1; tag_m[idx] = tg; dirty_m[idx] = 0;
      end
      if (w) begin gold[wi] = d; dirty_m[idx] = 1; rd_e = d; end
      else rd_e = gold[wi];
      mem_log.delete();
      start_req(w, a, d);
      finish_req(rd, hit, lat);
      chk({nm, "_hit"},   hit, hit_e);
      chk({nm, "_rdata"}, rd, rd_e);
      chk({nm, "_nmem"},  mem_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < mem_log.size(); i++) begin
         chk({nm, "_mwrite"}, mem_log[i].w, exp_q[i].w);
         chk({nm, "_maddr"},  mem_log[i].a, exp_q[i].a);
         if (exp_q[i].w) chk({nm, "_mwdata"}, mem_log[i].d, exp_q[i].d);
      end
      if (hit_e) chk({nm, "_lat"}, lat, 1);
      else if (exp_lat > 0) chk({nm, "_lat"}, lat, exp_lat);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d;
      int unsigned r;
      bit w;
      reset_i = 1'b1;
      cpu_req_valid_i = 1'b0; cpu_req_write_i = 1'b0; cpu_req_addr_i = '0; cpu_req_wdata_i = '0;
      mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_rdata_i = '0;
      for (int k = 0; k < MEMW; k++) mem[k] = $urandom;
      mem[32'h40] = 32'h11; mem[32'h41] = 32'h22; mem[32'h42] = 32'h33; mem[32'h43] = 32'h44;
      for (int k = 32'hC0; k < 32'hC4; k++) mem[k] = 32'h0;
      model_reset();
      #1;
      chk("rst_req_ready",  cpu_req_ready_o, 1'b1);
      chk("rst_resp_valid", cpu_resp_valid_o, 1'b0);
      chk("rst_resp_rdata", cpu_resp_rdata_o, 32'h0);
      chk("rst_resp_hit",   cpu_resp_hit_o, 1'b0);
      chk("rst_mem_valid",  mem_req_valid_o, 1'b0);
      chk("rst_mem_addr",   mem_req_addr_o, 32'h0);
      chk("rst_mem_wdata",  mem_req_wdata_o, 128'h0);
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;

      do_access(1'b0, 32'h100, 32'h0, 4, "cold_ld");
      do_access(1'b0, 32'h104, 32'h0, 0, "warm_ld");
      do_access(1'b1, 32'h108, 32'hDEADBEEF, 0, "st_hit");
      do_access(1'b0, 32'h108, 32'h0, 0, "ld_after_st");
      do_access(1'b0, 32'h200, 32'h0, 5, "dirty_evict");
      do_access(1'b1, 32'h304, 32'h5, 4, "st_miss");
      do_access(1'b0, 32'h304, 32'h0, 0, "ld_alloc");

      bp_cnt = 0; hold_ready = 5;
      do_access(1'b0, 32'h380, 32'h0, 9, "bp");
      chk("bp_cycles", bp_cnt, 5);
      hold_ready = 0;

      do_access(1'b0, 32'h100, 32'h0, 0, "reload");
      hold_resp = 1'b1; mem_log.delete();
      start_req(1'b0, 32'h340, 32'h0);
      for (int i = 0; i < 20 && mem_log.size() == 0; i++) @(negedge clk_i);
      chk("rst_rd_issued", mem_log.size(), 1);
      @(negedge clk_i); #2;
      reset_i = 1'b1; #1;
      chk("rstw_mem_valid",  mem_req_valid_o, 1'b0);
      chk("rstw_req_ready",  cpu_req_ready_o, 1'b1);
      chk("rstw_resp_valid", cpu_resp_valid_o, 1'b0);
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0; hold_resp = 1'b0;
      model_reset();
      do_access(1'b0, 32'h100, 32'h0, 4, "after_rst");

      hold_ready = 50; mem_log.delete();
      start_req(1'b1, 32'h3C4, 32'hCAFE);
      repeat (2) @(negedge clk_i);
      chk("rsta_pre_valid", mem_req_valid_o, 1'b1);
      #2;
      reset_i = 1'b1; #1;
      chk("rsta_mem_valid", mem_req_valid_o, 1'b0);
      chk("rsta_req_ready", cpu_req_ready_o, 1'b1);
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0; hold_ready = 0;
      model_reset();
      do_access(1'b0, 32'h3C4, 32'h0, 4, "after_rst2");

      fast = 1'b0; garbage = 1'b1;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 1023);
         a = r;
         w = ($urandom_range(0, 9) < 4);
         d = $urandom;
         do_access(w, a, d, 0, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
